// File: rtl/periph_bus_responder_pkg.sv
// Shared definitions for the peripheral bus responder: address window,
// register offsets, TCON bit positions and the 7-segment hex decode table.
// No ports; imported by the interface-level logic and sub-modules.
package periph_bus_responder_pkg;

  localparam logic [31:0] PERIPH_BASE_ADDR = 32'h4000_0000;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LED_W      = 8;
  localparam int unsigned SW_W       = 8;
  localparam int unsigned DIGI_OUT_W = 12;

  // Byte offsets inside the 32-byte window (addr[1:0] forced to zero).
  localparam logic [4:0] OFF_TH   = 5'h00;
  localparam logic [4:0] OFF_TL   = 5'h04;
  localparam logic [4:0] OFF_TCON = 5'h08;
  localparam logic [4:0] OFF_LED  = 5'h0C;
  localparam logic [4:0] OFF_SW   = 5'h10;
  localparam logic [4:0] OFF_DIGI = 5'h14;

  localparam int unsigned TCON_W  = 3;
  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  // Segment pattern {dp, g, f, e, d, c, b, a}, active-low, dp kept dark.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/periph_bus_responder_if.sv
// CPU data-bus bundle seen by the peripheral responder.
//   rd, wr       : read / write strobes
//   addr, wdata  : byte address and store data
//   rdata        : load data returned by the responder (same cycle)
interface periph_bus_responder_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/periph_bus_responder_digi_scan.sv
// Multiplexed 7-segment scanner: a free-running prescaler steps a 2-bit
// digit index every 2^SCAN_DIV cycles; drives one-hot-low anode + segments.
//   clk, reset : clock, async active-low reset
//   digits_i   : four hex nibbles, nibble 0 in [3:0]
//   digi_o     : {anode[3:0], seg[7:0]}, registered
module periph_bus_responder_digi_scan
  import periph_bus_responder_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           digits_i,
  output logic [DIGI_OUT_W-1:0] digi_o
);

  logic [SCAN_DIV-1:0]   cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [DIGI_OUT_W-1:0] digi_q, digi_d;
  logic [3:0]            nib_c;

  // Index advances as the prescaler wraps; output follows the new index.
  always_comb begin : scan_next
    cnt_d  = cnt_q + 1'b1;
    idx_d  = (cnt_q == '1) ? idx_q + 2'd1 : idx_q;
    nib_c  = digits_i[{idx_d, 2'b00} +: 4];
    digi_d = {~(4'b0001 << idx_d), hex_seg(nib_c)};
  end

  always_ff @(posedge clk or negedge reset) begin : scan_regs
    if (!reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      digi_q <= {4'b1110, 8'hFF};
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      digi_q <= digi_d;
    end
  end

  assign digi_o = digi_q;

endmodule

// File: rtl/periph_bus_responder.sv
// Memory-mapped peripheral responder: interval timer (TH/TL/TCON), LED
// register, synchronised switch input and 7-segment register at BASE_ADDR.
//   clk, reset : clock, async active-low reset
//   bus        : CPU data bus (slave side); rdata is combinational
//   switch     : asynchronous board switches
//   led        : LED register
//   digi       : {anode[3:0], seg[7:0]}
//   irq        : timer interrupt, level, registered
// Build option DIGI_SCAN_EN: DIGI widens to 16 bits and drives a scanned
// 4-digit display; otherwise digi is DIGI[11:0] verbatim.
module periph_bus_responder
  import periph_bus_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = PERIPH_BASE_ADDR,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SCAN_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  periph_bus_responder_if.slave bus,
  input  logic [SW_W-1:0]       switch,
  output logic [LED_W-1:0]      led,
  output logic [DIGI_OUT_W-1:0] digi,
  output logic                  irq
);

`ifdef DIGI_SCAN_EN
  localparam int unsigned DIGI_W = 16;
`else
  localparam int unsigned DIGI_W = 12;
`endif

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || SCAN_DIV == 0) begin : g_param_check
    $error("periph_bus_responder: SYNC_STAGES must be 2..4, SCAN_DIV nonzero");
  end

  logic [DATA_W-1:0] th_q, th_d, tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic              irq_q, irq_d;
  logic [SW_W-1:0]   sync_q [SYNC_STAGES];

  logic       hit_c, wr_hit_c, tl_max_c;
  logic [4:0] off_c;
  logic       unused_c;

  // Window decode; byte lanes are ignored.
  always_comb begin : decode
    hit_c    = (bus.addr[31:5] == BASE_ADDR[31:5]);
    off_c    = {bus.addr[4:2], 2'b00};
    wr_hit_c = bus.wr & hit_c;
    tl_max_c = &tl_q;
  end
  assign unused_c = ^bus.addr[1:0];

  // Register file and timer. A TL write overrides counting; an overflow
  // status set overrides a same-cycle clear so no event is dropped.
  always_comb begin : next_state
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    if (wr_hit_c && off_c == OFF_TH) th_d = bus.wdata;
    if (tcon_q[TCON_EN]) tl_d = tl_max_c ? th_q : tl_q + 32'd1;
    if (wr_hit_c && off_c == OFF_TL) tl_d = bus.wdata;
    if (wr_hit_c && off_c == OFF_TCON) tcon_d = bus.wdata[TCON_W-1:0];
    if (tcon_q[TCON_EN] && tcon_q[TCON_IE] && tl_max_c) tcon_d[TCON_IS] = 1'b1;
    if (wr_hit_c && off_c == OFF_LED) led_d = bus.wdata[LED_W-1:0];
    if (wr_hit_c && off_c == OFF_DIGI) digi_d = bus.wdata[DIGI_W-1:0];
    irq_d = tcon_d[TCON_IS] & tcon_d[TCON_IE];
  end

  always_ff @(posedge clk or negedge reset) begin : regs
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      irq_q  <= irq_d;
    end
  end

  // Switch synchroniser.
  always_ff @(posedge clk or negedge reset) begin : sw_sync
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= switch;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Zero-wait-state read mux.
  always_comb begin : read_mux
    bus.rdata = '0;
    if (bus.rd && hit_c) begin
      case (off_c)
        OFF_TH:   bus.rdata = th_q;
        OFF_TL:   bus.rdata = tl_q;
        OFF_TCON: bus.rdata = 32'(tcon_q);
        OFF_LED:  bus.rdata = 32'(led_q);
        OFF_SW:   bus.rdata = 32'(sync_q[SYNC_STAGES-1]);
        OFF_DIGI: bus.rdata = 32'(digi_q);
        default:  bus.rdata = '0;
      endcase
    end
  end

  assign led = led_q;
  assign irq = irq_q;

`ifdef DIGI_SCAN_EN
  periph_bus_responder_digi_scan #(.SCAN_DIV(SCAN_DIV)) u_digi_scan (
    .clk      (clk),
    .reset    (reset),
    .digits_i (digi_q),
    .digi_o   (digi)
  );
`else
  assign digi = digi_q;
`endif

endmodule

// File: tb/tb_periph_bus_responder.sv
// Bench for periph_bus_responder: expected outputs are queued as stimulus is
// driven and compared on the falling clock edge when the DUT presents them.
module tb_periph_bus_responder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned SDIV = 2;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED  = BASE + 32'h0C;
  localparam logic [31:0] A_SW   = BASE + 32'h10;
  localparam logic [31:0] A_DIGI = BASE + 32'h14;
`ifdef DIGI_SCAN_EN
  localparam logic [31:0] DIGI_MASK = 32'h0000_FFFF;
`else
  localparam logic [31:0] DIGI_MASK = 32'h0000_0FFF;
`endif
  localparam int K_RD = 0, K_LED = 1, K_IRQ = 2, K_DIGI = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;
  int          n_checks = 0;
  int          n_errors = 0;
  sb_t         sb_q[$];
  sb_t         mon_e;
  logic [31:0] mon_obs;

  periph_bus_responder_if bus_if();

  periph_bus_responder #(
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SYNC),
    .SCAN_DIV    (SDIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int kind, input logic [31:0] exp, input string tag);
    sb_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(posedge clk); #1;
    bus_if.wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic rd_v, input logic [31:0] exp,
                        input string tag);
    bus_if.rd = rd_v; bus_if.addr = a;
    expect_out(K_RD, exp, tag);
    @(posedge clk); #1;
    bus_if.rd = 1'b0;
  endtask

  // Active-high gfedcba patterns for 0..F.
  function automatic logic [6:0] seg_hi(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  // Scoreboard consumer: everything queued this cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_RD:    mon_obs = bus_if.rdata;
        K_LED:   mon_obs = {24'h0, led};
        K_IRQ:   mon_obs = {31'h0, irq};
        default: mon_obs = {20'h0, digi};
      endcase
      chk(mon_e.tag, mon_obs, mon_e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  an;
    logic [1:0]  idx, prev;
    logic [3:0]  nib;
    logic [15:0] dv;
    int          run;
    bit          have_prev, seen_change;

    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    switch = 8'h00; reset = 1'b0;
    tick(3);
    reset = 1'b1;

    // Reset state
    expect_out(K_LED, 32'h0, "rst_led");
    expect_out(K_IRQ, 32'h0, "rst_irq");
`ifndef DIGI_SCAN_EN
    expect_out(K_DIGI, 32'h0, "rst_digi");
`endif
    bus_rd(A_TH,   1'b1, 32'h0, "rst_th");
    bus_rd(A_TL,   1'b1, 32'h0, "rst_tl");
    bus_rd(A_TCON, 1'b1, 32'h0, "rst_tcon");
    bus_rd(A_LED,  1'b1, 32'h0, "rst_ledreg");
    bus_rd(A_SW,   1'b1, 32'h0, "rst_sw");
    bus_rd(A_DIGI, 1'b1, 32'h0, "rst_digireg");

    // Timer overflow and reload
    bus_wr(A_TH,   32'hFFFF_FFFD);
    bus_wr(A_TL,   32'hFFFF_FFFE);
    bus_wr(A_TCON, 32'h3);
    bus_rd(A_TL, 1'b1, 32'hFFFF_FFFE, "ovf_tl0");
    bus_rd(A_TL, 1'b1, 32'hFFFF_FFFF, "ovf_tl_max");
    expect_out(K_IRQ, 32'h1, "ovf_irq");
    bus_rd(A_TL, 1'b1, 32'hFFFF_FFFD, "ovf_reload");
    bus_rd(A_TCON, 1'b1, 32'h7, "ovf_tcon");

    // Status set in the same cycle as a clearing write
    bus_wr(A_TCON, 32'h0);
    bus_wr(A_TH,   32'h0);
    bus_wr(A_TL,   32'hFFFF_FFFE);
    bus_wr(A_TCON, 32'h3);
    expect_out(K_IRQ, 32'h0, "race_pre_irq");
    tick(1);
    bus_wr(A_TCON, 32'h3);
    expect_out(K_IRQ, 32'h1, "race_irq");
    bus_rd(A_TCON, 1'b1, 32'h7, "race_tcon");
    bus_wr(A_TCON, 32'h3);
    expect_out(K_IRQ, 32'h0, "clr_irq");
    bus_rd(A_TCON, 1'b1, 32'h3, "clr_tcon");

    // TL write wins over counting; disable holds
    bus_wr(A_TL, 32'h10);
    bus_rd(A_TL, 1'b1, 32'h10, "tlwr_0");
    bus_rd(A_TL, 1'b1, 32'h11, "tlwr_1");
    bus_wr(A_TCON, 32'h0);
    bus_rd(A_TL, 1'b1, 32'h13, "hold_0");
    bus_rd(A_TL, 1'b1, 32'h13, "hold_1");

    // LED, switch sync, unmapped and out-of-window accesses
    bus_wr(A_LED, 32'h0000_00A5);
    expect_out(K_LED, 32'hA5, "led_out");
    bus_rd(A_LED, 1'b1, 32'hA5, "led_rd");
    bus_rd(A_LED + 32'h2, 1'b1, 32'hA5, "led_rd_lane");
    switch = 8'h3C;
    for (int k = 0; k <= int'(SYNC); k++)
      bus_rd(A_SW, 1'b1, (k >= int'(SYNC)) ? 32'h3C : 32'h0, "sw_sync");
    bus_rd(BASE + 32'h1C, 1'b1, 32'h0, "unmapped_rd");
    bus_rd(A_LED, 1'b0, 32'h0, "rd_low");
    bus_wr(32'h5000_000C, 32'hFF);
    bus_wr(32'h5000_0000, 32'h1234_5678);
    expect_out(K_LED, 32'hA5, "oow_led");
    bus_rd(A_TH, 1'b1, 32'h0, "oow_th");
    bus_wr(A_DIGI, 32'hFFFF_FFFF);
    bus_rd(A_DIGI, 1'b1, DIGI_MASK, "digi_width");
    bus_wr(A_DIGI, 32'h0000_0ABC);
`ifndef DIGI_SCAN_EN
    expect_out(K_DIGI, 32'hABC, "digi_out");
`endif
    bus_rd(A_DIGI, 1'b1, 32'hABC, "digi_rd");

    // Status test hook, then asynchronous reset mid-operation
    bus_wr(A_TCON, 32'h7);
    expect_out(K_IRQ, 32'h1, "hook_irq");
    bus_rd(A_TCON, 1'b1, 32'h7, "hook_tcon");
    reset = 1'b0;
    bus_if.rd = 1'b1; bus_if.addr = A_TCON;
    expect_out(K_RD, 32'h0, "arst_tcon");
    expect_out(K_LED, 32'h0, "arst_led");
    expect_out(K_IRQ, 32'h0, "arst_irq");
`ifndef DIGI_SCAN_EN
    expect_out(K_DIGI, 32'h0, "arst_digi");
`endif
    @(posedge clk); #1;
    bus_if.rd = 1'b0;
    reset = 1'b1;
    bus_rd(A_TL, 1'b1, 32'h0, "arst_tl");

`ifdef DIGI_SCAN_EN
    // Scanned display: anode order and dwell, segment decode per digit
    dv = 16'h1234;
    bus_wr(A_DIGI, {16'h0, dv});
    tick(2);
    have_prev = 1'b0; seen_change = 1'b0; run = 0; prev = 2'd0;
    repeat (40) begin
      @(negedge clk);
      an = digi[11:8];
      case (an)
        4'b1110: idx = 2'd0;
        4'b1101: idx = 2'd1;
        4'b1011: idx = 2'd2;
        4'b0111: idx = 2'd3;
        default: begin idx = 2'd0; chk("scan_anode", {28'h0, an}, 32'hE); end
      endcase
      nib = dv[{idx, 2'b00} +: 4];
      chk("scan_seg", {24'h0, digi[7:0]}, {24'h0, 1'b1, ~seg_hi(nib)});
      if (have_prev && idx != prev) begin
        chk("scan_step", {30'h0, idx}, {30'h0, 2'(prev + 2'd1)});
        if (seen_change) chk("scan_period", 32'(run), 32'd4);
        seen_change = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev = idx;
      have_prev = 1'b1;
    end
    @(posedge clk); #1;
`endif

    tick(2);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
